// File: rtl/write_back_arb.sv
// Write-back arbiter: round-robin merge of NCH result channels onto one register-file write port,
// with a HIST-deep commit history for forwarding. Optional load alignment on channel 0 via WB_LOAD_ALIGN_EN.
module write_back_arb #(
    parameter int NCH  = 2,
    parameter int XLEN = 32,
    parameter int RW   = 5,
    parameter int HIST = 2
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic [NCH-1:0]         in_wreg,
    input  logic [NCH*RW-1:0]      in_rd,
    input  logic [NCH*XLEN-1:0]    in_data,
    input  logic [2:0]             ld_funct3,
    input  logic [1:0]             ld_offset,
    output logic                   Wreg,
    output logic [RW-1:0]          rd,
    output logic [XLEN-1:0]        Wdata,
    output logic [HIST-1:0]        hist_valid,
    output logic [HIST*RW-1:0]     hist_rd,
    output logic [HIST*XLEN-1:0]   hist_data,
    output logic [31:0]            retire_count
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0]   rr_q, rr_d;
    logic [31:0]     retire_q, retire_d;
    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [XLEN-1:0] ch_data [NCH];
    logic            sel_wreg;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            hist_v_q    [HIST];
    logic [RW-1:0]   hist_rd_q   [HIST];
    logic [XLEN-1:0] hist_data_q [HIST];

`ifdef WB_LOAD_ALIGN_EN
    // Channel 0 carries the raw memory word; extract and extend the addressed byte/half.
    function automatic logic [31:0] align_load(input logic [31:0] w,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction
`else
    logic unused_load_ctrl;
    assign unused_load_ctrl = ^{ld_funct3, ld_offset};
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            if (gi == 0) begin : g_ch0
`ifdef WB_LOAD_ALIGN_EN
                assign ch_data[gi] = align_load(in_data[31:0], ld_funct3, ld_offset);
`else
                assign ch_data[gi] = in_data[gi*XLEN +: XLEN];
`endif
            end else begin : g_chn
                assign ch_data[gi] = in_data[gi*XLEN +: XLEN];
            end
        end
    endgenerate

    // Search starts at rr_q and wraps; the first valid channel wins.
    always_comb begin : arbiter
        logic [PW-1:0]  idx;
        logic [NCH-1:0] vshift;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = rr_q;
        vshift    = '0;
        for (int k = 0; k < NCH; k++) begin
            vshift = in_valid >> idx;
            if (!grant_vld && vshift[0]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
            idx = (idx == PW'(NCH - 1)) ? '0 : idx + PW'(1);
        end
        if (!nReset) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin : commit_mux
        in_ready = '0;
        sel_wreg = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant_vld && (grant_idx == PW'(k))) begin
                in_ready[k] = 1'b1;
                sel_wreg    = in_wreg[k];
                sel_rd      = in_rd[k*RW +: RW];
                sel_data    = ch_data[k];
            end
        end
        Wreg  = sel_wreg && (sel_rd != '0);
        rd    = sel_rd;
        Wdata = sel_data;
    end

    always_comb begin : next_state
        rr_d     = rr_q;
        retire_d = retire_q;
        if (grant_vld) begin
            rr_d     = (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            rr_q     <= '0;
            retire_q <= '0;
        end else begin
            rr_q     <= rr_d;
            retire_q <= retire_d;
        end
    end

    // History shifts every cycle; idle cycles insert a valid=0 bubble.
    generate
        for (genvar gi = 0; gi < HIST; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                always_ff @(posedge Clock) begin
                    if (!nReset) begin
                        hist_v_q[gi]    <= 1'b0;
                        hist_rd_q[gi]   <= '0;
                        hist_data_q[gi] <= '0;
                    end else begin
                        hist_v_q[gi]    <= Wreg;
                        hist_rd_q[gi]   <= rd;
                        hist_data_q[gi] <= Wdata;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge Clock) begin
                    if (!nReset) begin
                        hist_v_q[gi]    <= 1'b0;
                        hist_rd_q[gi]   <= '0;
                        hist_data_q[gi] <= '0;
                    end else begin
                        hist_v_q[gi]    <= hist_v_q[gi-1];
                        hist_rd_q[gi]   <= hist_rd_q[gi-1];
                        hist_data_q[gi] <= hist_data_q[gi-1];
                    end
                end
            end
            assign hist_valid[gi]               = hist_v_q[gi];
            assign hist_rd[gi*RW +: RW]         = hist_rd_q[gi];
            assign hist_data[gi*XLEN +: XLEN]   = hist_data_q[gi];
        end
    endgenerate

    assign retire_count = retire_q;

endmodule
